uart_rx_sequencer: RTL
======================

// Module: uart_rx_sequencer
// PURPOSE
//  Receive-side controller for the 10-bit UART frame (1 start, 8 data, 1 stop, no parity).
//  Owns and sequences a baud_counter instance that generates 16x-oversample ticks.
//  Detects the start bit, samples each bit at mid-bit, and assembles the byte.
//  Presents received data with a valid/ack handshake, plus frame, overrun and config errors.
// PARAMETERS
//  DATA_BITS    8   data bits per frame, sent LSB first
//  OS_RATE      16  oversample ticks per bit; must be even
//  CNT_W        20  width of the baud divisor and its counter
//  SYNC_STAGES  2   flops in the rx input synchroniser (minimum 2)
// PORTS
//  clk        in   1          system clock; single clock domain
//  rst        in   1          synchronous, active-high reset
//  rx_en      in   1          receiver enable; low = abort and stay idle
//  baud       in   CNT_W      tick divisor; one tick every baud+1 clk; legal when >= 16
//  rx         in   1          serial line; asynchronous; idles high
//  rx_data    out  DATA_BITS  last received byte; held until the next good frame
//  rx_valid   out  1          1-cycle pulse when a good frame completes
//  rx_pending out  1          set by rx_valid, cleared by rx_ack
//  rx_ack     in   1          consumer has taken rx_data
//  frame_err  out  1          1-cycle pulse when the stop bit samples 0
//  overrun    out  1          1-cycle pulse when a good frame completes while rx_pending=1
//  cfg_err    out  1          level output; high while baud < 16
//  busy       out  1          high in every state except IDLE
// BEHAVIOUR
//  Reset values: every output is 0, the FSM is in IDLE, the synchroniser flops are 1,
//   and the tick counter and baud counter are 0.
//  Synchroniser: rx_s is rx delayed by SYNC_STAGES clk. All decisions use rx_s.
//  Baud tick: the baud counter is enabled in every state except IDLE.
//   The tick fires when cnt==baud_l, and the counter then wraps to 0.
//   baud_l is baud latched on the IDLE->START transition. Changes to baud mid-frame are ignored.
//  os_cnt: a 4-bit count of ticks, cleared on every state change.
//  FSM states:
//   IDLE:  leave when rx_en && !cfg_err && rx_s==0 -> START. The baud counter is held at 0.
//   START: at tick number OS_RATE/2 (mid start bit):
//          rx_s==0 -> DATA, bit_idx=0; rx_s==1 -> IDLE (glitch rejected, no flags raised).
//   DATA:  every OS_RATE ticks, shift rx_s into shreg[bit_idx] and increment bit_idx.
//          After bit DATA_BITS-1 is sampled -> STOP.
//   STOP:  at tick OS_RATE, sample rx_s, then go to IDLE on the next clk.
//          rx_s==1: rx_data<=shreg, rx_valid=1, rx_pending=1.
//            If rx_pending was already 1, overrun=1 and rx_data is overwritten.
//          rx_s==0: frame_err=1; rx_data and rx_pending are unchanged.
//  Return to IDLE happens at mid stop bit, so back-to-back frames are accepted.
//  Timing at baud=16: one bit is 17*16=272 clk. The data-bit-0 sample lands 8*17+272 clk
//   after the falling edge is seen in rx_s.
//  rx_valid is asserted 1 clk after the stop-bit sample tick.
//  rx_ack: clears rx_pending on the clk it is seen high. Ack together with rx_valid in the
//   same clk: set wins (pending stays 1, no overrun). Ack while not pending has no effect.
//  rx_en low in any state: next clk -> IDLE; the partial byte is discarded; no pulses;
//   rx_pending and rx_data are kept.
//  baud < 16: cfg_err=1 and the block stays in IDLE. If baud drops below 16 mid-frame, the
//   frame completes using baud_l.
//  rst mid-frame: every output returns to its reset value on the next clk edge.
//  rx_valid, frame_err and overrun are never asserted in the same clk, except rx_valid+overrun.
// STRUCTURE
//  Shared package uart_pkg: state encoding (IDLE/START/DATA/STOP), OS_RATE, DATA_BITS,
//   BAUD_MIN=16, CNT_W.
//  Sub-module: baud_counter (the existing combinational next-count block). This module owns
//   its CNT_W count register and drives en=busy, baud=baud_l, rst=rst.
//  Everything else is in this module: synchroniser, FSM, os_cnt, bit_idx, shreg, output flags.
// TESTING
//  1. baud=16; send 0xA5, 8N1 -> rx_valid once, rx_data=0xA5, rx_pending=1, no errors;
//     rx_ack -> rx_pending=0.
//  2. rx low for 100 clk only (shorter than half a bit at baud=16) -> return to IDLE,
//     no rx_valid, busy low again before clk 200.
//  3. Send 0x3C with the stop bit driven 0 -> frame_err pulse, rx_data unchanged,
//     rx_valid stays 0.
//  4. Send 0x11 then 0x22 back-to-back with no ack -> second rx_valid has overrun=1,
//     rx_data=0x22.
//  5. baud=15 with a falling edge on rx -> cfg_err=1, busy stays 0; then baud=16 and send 0x5A
//     -> received correctly.
//  6. Drop rx_en mid DATA (after 3 bits of 0xFF) -> IDLE next clk, no pulses; the next frame
//     0x81 is received correctly.
//  7. rst asserted mid STOP -> all outputs 0 next clk.
//  8. rx_ack in the same clk as rx_valid -> rx_pending stays 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART receive path.
package uart_pkg;
    localparam int DATA_BITS = 8;
    localparam int OS_RATE   = 16;
    localparam int CNT_W     = 20;
    localparam int BAUD_MIN  = 16;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;
endpackage

// File: rtl/uart_rx_sequencer_baud_counter.sv
// Next-count logic for the oversample baud counter; the caller owns the register.
module baud_counter #(
    parameter int CNT_W = 20
) (
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] baud,
    input  logic [CNT_W-1:0] cnt_q,
    output logic [CNT_W-1:0] cnt_d,
    output logic             tick
);
    always_comb begin
        tick = en && (cnt_q == baud);
        if (rst || !en || tick) cnt_d = '0;
        else                    cnt_d = cnt_q + CNT_W'(1);
    end
endmodule

// File: rtl/uart_rx_sequencer.sv
// 8N1 UART receiver: input synchroniser, mid-bit sampling FSM, valid/ack handshake
// with frame, overrun and configuration error reporting.
module uart_rx_sequencer #(
    parameter int DATA_BITS   = uart_pkg::DATA_BITS,
    parameter int OS_RATE     = uart_pkg::OS_RATE,
    parameter int CNT_W       = uart_pkg::CNT_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_en,
    input  logic [CNT_W-1:0]     baud,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_pending,
    input  logic                 rx_ack,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 cfg_err,
    output logic                 busy
);
    import uart_pkg::*;

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [3:0] OS_LAST = 4'(OS_RATE - 1);
    localparam logic [3:0] OS_MID  = 4'(OS_RATE / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    rx_state_e               state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q, sync_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d, baud_l_q, baud_l_d;
    logic [3:0]              os_cnt_q, os_cnt_d;
    logic [IDX_W-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]    shreg_q, shreg_d, rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d, rx_pending_q, rx_pending_d;
    logic                    frame_err_q, frame_err_d, overrun_q, overrun_d;
    logic                    cfg_err_q, cfg_err_d;
    logic                    rx_s, tick, baud_bad, good;

    assign busy       = (state_q != IDLE);
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign rx_pending = rx_pending_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign cfg_err    = cfg_err_q;

    baud_counter #(.CNT_W(CNT_W)) u_baud (
        .rst   (rst),
        .en    (busy),
        .baud  (baud_l_q),
        .cnt_q (cnt_q),
        .cnt_d (cnt_d),
        .tick  (tick)
    );

    always_comb begin
        rx_s        = sync_q[SYNC_STAGES-1];
        sync_d      = {sync_q[SYNC_STAGES-2:0], rx};
        baud_bad    = (baud < CNT_W'(BAUD_MIN));
        cfg_err_d   = baud_bad;
        state_d     = state_q;
        os_cnt_d    = os_cnt_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        baud_l_d    = baud_l_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        good        = 1'b0;

        case (state_q)
            IDLE: begin
                os_cnt_d = '0;
                if (rx_en && !baud_bad && !rx_s) begin
                    state_d  = START;
                    baud_l_d = baud;
                end
            end
            START: if (tick) begin
                os_cnt_d = os_cnt_q + 4'd1;
                if (os_cnt_q == OS_MID) begin
                    state_d   = rx_s ? IDLE : DATA;
                    os_cnt_d  = '0;
                    bit_idx_d = '0;
                end
            end
            DATA: if (tick) begin
                os_cnt_d = (os_cnt_q == OS_LAST) ? 4'd0 : os_cnt_q + 4'd1;
                if (os_cnt_q == OS_LAST) begin
                    shreg_d[bit_idx_q] = rx_s;
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                    if (bit_idx_q == IDX_LAST) state_d = STOP;
                end
            end
            STOP: if (tick) begin
                os_cnt_d = os_cnt_q + 4'd1;
                if (os_cnt_q == OS_LAST) begin
                    state_d     = IDLE;
                    os_cnt_d    = '0;
                    good        = rx_s;
                    frame_err_d = !rx_s;
                end
            end
            default: state_d = IDLE;
        endcase

        // Disable wins over everything, including a stop sample in the same cycle.
        if (!rx_en && state_q != IDLE) begin
            state_d     = IDLE;
            os_cnt_d    = '0;
            good        = 1'b0;
            frame_err_d = 1'b0;
        end

        if (good) begin
            rx_data_d  = shreg_q;
            rx_valid_d = 1'b1;
            overrun_d  = rx_pending_q;
        end
        // An ack seen during the rx_valid cycle belongs to the older byte and is ignored.
        if (good)                        rx_pending_d = 1'b1;
        else if (rx_ack && !rx_valid_q)  rx_pending_d = 1'b0;
        else                             rx_pending_d = rx_pending_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sync_q       <= '1;
            cnt_q        <= '0;
            baud_l_q     <= '0;
            os_cnt_q     <= '0;
            bit_idx_q    <= '0;
            shreg_q      <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_pending_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            cnt_q        <= cnt_d;
            baud_l_q     <= baud_l_d;
            os_cnt_q     <= os_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shreg_q      <= shreg_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_pending_q <= rx_pending_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            cfg_err_q    <= cfg_err_d;
        end
    end
endmodule
